cineraria_sysid_checker: RTL and testbench
==========================================

# cineraria_sysid_checker

Avalon-MM read initiator that fetches the two system-ID words (ID at word address 0, build timestamp at word address 1) from the system-ID responder and compares them with expected values. It reports the compare result to boot/supervisor logic. It sits beside the control bus master and gives software-independent confirmation that the loaded FPGA image matches the one the firmware was built for.

## Interface
Parameters:
- EXPECTED_ID, 32'h2015_0910, expected word at address 0
- EXPECTED_TS, 32'h55F1_7042, expected word at address 1
- CHECK_TS, 1, 1 = timestamp mismatch clears `match`; 0 = timestamp is captured only
- TIMEOUT_CYCLES, 255, max stalled cycles per read; 0 disables the timeout (8-bit counter, range 0..255)
- AUTO_START, 1, 1 = run one check automatically after reset release

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run a check; ignored while `busy`
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes
- match  out  1  id_ok & (ts_ok | ~CHECK_TS), valid from `done` until the next start
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TS
- timeout  out  1  the last check aborted on a stalled read
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- avm_address  out  1  word address to responder
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  responder stall
- avm_readdata  in  32  read data, valid in the accept cycle

One clock. Reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, FIN.
- IDLE: on `start`, or on the first cycle after reset release when AUTO_START=1, clear id_ok, ts_ok, match and timeout, then go to RD_ID.
- RD_ID: avm_read=1, avm_address=0.
  - On accept (avm_read & ~avm_waitrequest), capture avm_readdata into id_value, set id_ok = (data==EXPECTED_ID), go to RD_TS.
- RD_TS: avm_read=1, avm_address=1.
  - On accept, capture ts_value, set ts_ok, go to FIN.
- FIN: done=1 and match registered for one cycle, then return to IDLE.
- busy=1 in RD_ID, RD_TS and FIN.
- Stall counter: cleared on entry to each read state. It increments on each cycle with avm_read & avm_waitrequest.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with the read still stalled, drop avm_read, set timeout=1, force id_ok, ts_ok and match to 0, and go to FIN.
- `start` asserted in any non-IDLE state is dropped, not queued.
- avm_address and avm_read are registered outputs. They stay stable while avm_waitrequest=1.
- Compares are full 32-bit equality. No masking.

## Timing
- Reset values: busy=0, done=0, match=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, avm_read=0, avm_address=0. The FSM resets to IDLE.
- Reset asserted mid-read drops avm_read on the next edge. No done pulse is produced.
- With a zero-wait responder:
  - start sampled at edge 0
  - avm_read with address 0 during cycle 1
  - address 1 during cycle 2
  - done high during cycle 3
- Each stalled cycle adds exactly one cycle of latency.
- Back-to-back reads: avm_read stays high across the RD_ID→RD_TS transition. Only the address changes.
- A timeout fires after exactly TIMEOUT_CYCLES stalled cycles. done follows on the next cycle.
- start in the same cycle as done (FIN) is ignored. start in the cycle after done is accepted.

## Structure
- Package `cineraria_sysid_pkg`:
  - state enum
  - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
  - stall counter width (8)
- Single module with no sub-modules. The stall counter is inline.

## Test plan
- Zero-wait responder returning 0x20150910 / 0x55F17042; start pulse → done in cycle 3, match=1, id_ok=1, ts_ok=1, timeout=0.
- Responder returns ID 0x20150911 → id_ok=0, match=0, id_value=0x20150911; ts_ok=1.
- Timestamp 0x00000000 with CHECK_TS=0 → match=1, ts_ok=0. With CHECK_TS=1 → match=0.
- waitrequest held 3 cycles on each read → done 6 cycles later than the zero-wait case; address and read stay stable while stalled.
- waitrequest held permanently, TIMEOUT_CYCLES=4 → avm_read drops after 4 stalled cycles, timeout=1, match=0, done pulses once.
- AUTO_START=1 → check runs with no start pulse. Reset mid-RD_TS → avm_read=0 next cycle, no done; a later check runs normally. start while busy is ignored.

Source files
------------

// File: rtl/cineraria_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
// No logic; pure declarations.
// No flow control of its own.
package cineraria_sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/cineraria_sysid_checker.sv
// Reads the system-ID and build-timestamp words over Avalon-MM and compares them to the expected image.
// Latency: done three cycles after start with a zero-wait responder, plus one per stalled cycle.
// Backpressure: honours avm_waitrequest with stable address/read; optional stall timeout aborts the check.
module cineraria_sysid_checker
    import cineraria_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h2015_0910,
    parameter logic [31:0] EXPECTED_TS    = 32'h55F1_7042,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    // Counter value on the stalled cycle that must trip the timeout.
    localparam logic [STALL_CNT_W-1:0] TO_LAST = STALL_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   auto_pend;
    logic                   launch;
    logic                   accept;
    logic                   stall;
    logic                   tmo_hit;

    // Any non-idle state counts as a check in flight, including the FIN reporting cycle.
    assign busy = (state != ST_IDLE);

    // Next-state decode and per-cycle bus events.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        accept     = avm_read & ~avm_waitrequest;
        stall      = avm_read & avm_waitrequest;
        tmo_hit    = (TIMEOUT_CYCLES != 0) && stall && (stall_cnt == TO_LAST);
        unique case (state)
            ST_IDLE: begin
                if (start || auto_pend) begin
                    launch     = 1'b1;
                    state_next = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                if (tmo_hit) begin
                    state_next = ST_FIN;
                end else if (accept) begin
                    state_next = ST_RD_TS;
                end
            end
            ST_RD_TS: begin
                if (tmo_hit || accept) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, registered bus strobes, stall counter and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            auto_pend   <= AUTO_START;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            done        <= 1'b0;
            match       <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            stall_cnt   <= '0;
        end else begin
            state     <= state_next;
            // Only the very first post-reset idle cycle may self-launch.
            auto_pend <= 1'b0;
            // Strobes decoded from the next state so they change only on state changes,
            // which keeps them steady while the responder stalls.
            avm_read    <= (state_next == ST_RD_ID) || (state_next == ST_RD_TS);
            avm_address <= (state_next == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            done        <= (state_next == ST_FIN);

            if (state_next != state) begin
                stall_cnt <= '0;
            end else if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (launch) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                match   <= 1'b0;
                timeout <= 1'b0;
            end

            if (state == ST_RD_ID || state == ST_RD_TS) begin
                if (tmo_hit) begin
                    timeout <= 1'b1;
                    id_ok   <= 1'b0;
                    ts_ok   <= 1'b0;
                    match   <= 1'b0;
                end else if (accept && state == ST_RD_ID) begin
                    id_value <= avm_readdata;
                    id_ok    <= (avm_readdata == EXPECTED_ID);
                end else if (accept) begin
                    ts_value <= avm_readdata;
                    ts_ok    <= (avm_readdata == EXPECTED_TS);
                    match    <= id_ok && ((avm_readdata == EXPECTED_TS) || !CHECK_TS);
                end
            end
        end
    end

endmodule

// File: tb/tb_cineraria_sysid_checker.sv
// Bench for the system-ID checker: two instances with different parameter sets.
// Instance 0: CHECK_TS=1, TIMEOUT=255, AUTO_START=1. Instance 1: CHECK_TS=0, TIMEOUT=4, AUTO_START=0.
// Each instance has its own stalling responder; results are predicted from read counts and stall budgets.
module tb_cineraria_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h2015_0910;
    localparam logic [31:0] EXP_TS = 32'h55F1_7042;
    localparam int          NEVER  = 1000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        start_s[2], busy_s[2], done_s[2], match_s[2], idok_s[2], tsok_s[2], tmo_s[2];
    logic        ad_s[2], rd_s[2], wreq_s[2];
    logic [31:0] idv_s[2], tsv_s[2], rdata_s[2], id_w[2], ts_w[2];
    logic [31:0] last_id[2], last_ts[2];
    int          s_id_r[2], s_ts_r[2], cnt_s[2];
    int          p_to[2]  = '{255, 4};
    bit          p_chk[2] = '{1'b1, 1'b0};
    int          checks = 0;
    int          errors = 0;

    cineraria_sysid_checker #(
        .CHECK_TS(1'b1), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .match(match_s[0]), .id_ok(idok_s[0]), .ts_ok(tsok_s[0]), .timeout(tmo_s[0]),
        .id_value(idv_s[0]), .ts_value(tsv_s[0]), .avm_address(ad_s[0]), .avm_read(rd_s[0]),
        .avm_waitrequest(wreq_s[0]), .avm_readdata(rdata_s[0])
    );

    cineraria_sysid_checker #(
        .CHECK_TS(1'b0), .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .match(match_s[1]), .id_ok(idok_s[1]), .ts_ok(tsok_s[1]), .timeout(tmo_s[1]),
        .id_value(idv_s[1]), .ts_value(tsv_s[1]), .avm_address(ad_s[1]), .avm_read(rd_s[1]),
        .avm_waitrequest(wreq_s[1]), .avm_readdata(rdata_s[1])
    );

    // Responder: stalls each read for the configured number of cycles, then returns the word.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            wreq_s[d]  = rd_s[d] && (cnt_s[d] < (ad_s[d] ? s_ts_r[d] : s_id_r[d]));
            rdata_s[d] = ad_s[d] ? ts_w[d] : id_w[d];
        end
    end

    // Responder stall counter: restarts after every accept or when no read is pending.
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset || !rd_s[d] || !wreq_s[d]) cnt_s[d] <= 0;
            else                                 cnt_s[d] <= cnt_s[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one check on instance d and compares against the predicted outcome.
    // pulse=0 means the check was launched by reset release instead of start.
    // x1: cycle whose closing edge also sees start (must be ignored); fin_start: start during done.
    task automatic run(input string tag, input int d, input bit pulse,
                       input logic [31:0] idw, input logic [31:0] tsw,
                       input int sid, input int sts, input int x1, input bit fin_start);
        int          to, n_id, n_ts, lat_exp, lat, tm;
        bit          tmo_id, tmo_ts, tmo;
        logic        e_idok, e_tsok, e_match;
        logic [31:0] e_idv, e_tsv;
        logic        o_idok, o_tsok, o_match, o_tmo, o_busy;
        logic [31:0] o_idv, o_tsv;
        to      = p_to[d];
        tmo_id  = (to != 0) && (sid >= to);
        tmo_ts  = !tmo_id && (to != 0) && (sts >= to);
        tmo     = tmo_id || tmo_ts;
        n_id    = tmo_id ? to : sid + 1;
        n_ts    = tmo_id ? 0 : (tmo_ts ? to : sts + 1);
        lat_exp = n_id + n_ts + 1;
        e_idv   = tmo_id ? last_id[d] : idw;
        e_tsv   = tmo ? last_ts[d] : tsw;
        e_idok  = !tmo && (idw == EXP_ID);
        e_tsok  = !tmo && (tsw == EXP_TS);
        e_match = e_idok && (e_tsok || !p_chk[d]);

        id_w[d]   = idw;
        ts_w[d]   = tsw;
        s_id_r[d] = sid;
        s_ts_r[d] = sts;
        if (pulse) start_s[d] = 1'b1;
        lat = -1;
        tm  = 0;
        o_idok = 0; o_tsok = 0; o_match = 0; o_tmo = 0; o_busy = 0; o_idv = 0; o_tsv = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clock);
            if (k < lat_exp) begin
                if (rd_s[d] !== 1'b1 || ad_s[d] !== logic'(k > n_id) ||
                    done_s[d] !== 1'b0 || busy_s[d] !== 1'b1) tm++;
            end
            start_s[d] = (k == x1) || (fin_start && done_s[d] === 1'b1);
            if (done_s[d] === 1'b1) begin
                lat = k;
                if (rd_s[d] !== 1'b0) tm++;
                o_idok = idok_s[d]; o_tsok = tsok_s[d]; o_match = match_s[d];
                o_tmo = tmo_s[d]; o_busy = busy_s[d]; o_idv = idv_s[d]; o_tsv = tsv_s[d];
                break;
            end
        end
        chk({tag, ".latency"}, lat, lat_exp);
        chk({tag, ".bus_trace_errs"}, tm, 0);
        chk({tag, ".busy_in_fin"}, o_busy, 1);
        chk({tag, ".timeout"}, o_tmo, tmo);
        chk({tag, ".id_ok"}, o_idok, e_idok);
        chk({tag, ".ts_ok"}, o_tsok, e_tsok);
        chk({tag, ".match"}, o_match, e_match);
        chk({tag, ".id_value"}, o_idv, e_idv);
        chk({tag, ".ts_value"}, o_tsv, e_tsv);
        last_id[d] = e_idv;
        last_ts[d] = e_tsv;
        @(negedge clock);
        start_s[d] = 1'b0;
        chk({tag, ".done_single"}, done_s[d], 0);
        chk({tag, ".idle_after"}, busy_s[d], 0);
        chk({tag, ".match_held"}, match_s[d], e_match);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            id_w[d] = EXP_ID; ts_w[d] = EXP_TS;
            s_id_r[d] = 0; s_ts_r[d] = 0;
            last_id[d] = '0; last_ts[d] = '0;
        end
        repeat (3) @(negedge clock);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d.busy", d), busy_s[d], 0);
            chk($sformatf("rst%0d.done", d), done_s[d], 0);
            chk($sformatf("rst%0d.match", d), match_s[d], 0);
            chk($sformatf("rst%0d.id_ok", d), idok_s[d], 0);
            chk($sformatf("rst%0d.ts_ok", d), tsok_s[d], 0);
            chk($sformatf("rst%0d.timeout", d), tmo_s[d], 0);
            chk($sformatf("rst%0d.id_value", d), idv_s[d], 0);
            chk($sformatf("rst%0d.ts_value", d), tsv_s[d], 0);
            chk($sformatf("rst%0d.avm_read", d), rd_s[d], 0);
            chk($sformatf("rst%0d.avm_address", d), ad_s[d], 0);
        end

        reset = 1'b0;
        run("auto_start", 0, 1'b0, EXP_ID, EXP_TS, 0, 0, 0, 1'b0);
        chk("b_no_auto_start", busy_s[1], 0);

        run("zero_wait",   0, 1'b1, EXP_ID, EXP_TS, 0, 0, 0, 1'b0);
        run("bad_id",      0, 1'b1, 32'h2015_0911, EXP_TS, 0, 0, 0, 1'b0);
        run("ts0_checked", 0, 1'b1, EXP_ID, 32'h0, 0, 0, 0, 1'b0);
        run("ts0_ignored", 1, 1'b1, EXP_ID, 32'h0, 0, 0, 0, 1'b0);
        run("stall3",      0, 1'b1, EXP_ID, EXP_TS, 3, 3, 0, 1'b0);
        run("stall3_b",    1, 1'b1, EXP_ID, EXP_TS, 3, 3, 0, 1'b0);
        run("hang_id",     1, 1'b1, EXP_ID, EXP_TS, NEVER, 0, 0, 1'b0);
        run("hang_ts",     1, 1'b1, EXP_ID, EXP_TS, 3, NEVER, 0, 1'b0);
        run("recover_b",   1, 1'b1, EXP_ID, EXP_TS, 0, 0, 0, 1'b0);
        run("start_busy",  0, 1'b1, EXP_ID, EXP_TS, 2, 2, 2, 1'b1);

        // Reset while the timestamp read is stalled.
        id_w[0] = EXP_ID; ts_w[0] = EXP_TS;
        s_id_r[0] = 0; s_ts_r[0] = NEVER;
        start_s[0] = 1'b1;
        @(negedge clock);
        start_s[0] = 1'b0;
        @(negedge clock);
        chk("midrst.in_rd_ts_addr", ad_s[0], 1);
        chk("midrst.in_rd_ts_read", rd_s[0], 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst.read_dropped", rd_s[0], 0);
        chk("midrst.no_done", done_s[0], 0);
        chk("midrst.not_busy", busy_s[0], 0);
        s_ts_r[0] = 0;
        for (int d = 0; d < 2; d++) begin
            last_id[d] = '0; last_ts[d] = '0;
        end
        reset = 1'b0;
        run("after_reset_auto", 0, 1'b0, EXP_ID, EXP_TS, 0, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int          d;
            logic [31:0] idw, tsw;
            d   = int'($urandom_range(0, 1));
            idw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            tsw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            run($sformatf("rnd%0d", i), d, 1'b1, idw, tsw,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
